// File: rtl/test_sequencer_pkg.sv
// Shared types and constants for the test sequencer and its blink-code generator.
package test_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_SETTLE,
      ST_START,
      ST_RUN,
      ST_GAP,
      ST_DONE
   } seq_state_t;

   typedef enum logic [1:0] {
      BL_ON,
      BL_OFF,
      BL_GAP
   } blink_phase_t;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } led_t;

   localparam led_t LED_OFF   = '{r: 1'b0, g: 1'b0, b: 1'b0};
   localparam led_t LED_RED   = '{r: 1'b1, g: 1'b0, b: 1'b0};
   localparam led_t LED_GREEN = '{r: 1'b0, g: 1'b1, b: 1'b0};
   localparam led_t LED_BLUE  = '{r: 1'b0, g: 1'b0, b: 1'b1};

   // Dark gap after a blink-code burst, in units of one blink half-period.
   localparam int unsigned BLINK_GAP_MULT = 4;

   // Bits needed to hold the values 0..limit.
   function automatic int unsigned width_of(input int unsigned limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/test_sequencer_blink_code.sv
// blink_code: repeating pulse train of i_count pulses (on/off of BLINK_CYCLES each)
// followed by a dark gap of BLINK_GAP_MULT*BLINK_CYCLES. Restarts from the first
// pulse whenever i_en is low.
module blink_code
   import test_sequencer_pkg::*;
#(
   parameter int unsigned BLINK_CYCLES = 12_000_000,
   parameter int unsigned COUNT_W      = 5
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic [COUNT_W-1:0] i_count,
   output logic               o_led
);

   localparam int unsigned GAP_CYCLES = BLINK_GAP_MULT * BLINK_CYCLES;
   localparam int unsigned TW         = width_of(GAP_CYCLES);
   localparam logic [TW-1:0] HALF_LAST = TW'(BLINK_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

   blink_phase_t       phase, phase_next;
   logic [TW-1:0]      timer, timer_next;
   logic [COUNT_W-1:0] pulse, pulse_next;

   // Phase, timer and pulse-count registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         phase <= BL_ON;
         timer <= '0;
         pulse <= '0;
      end else begin
         phase <= phase_next;
         timer <= timer_next;
         pulse <= pulse_next;
      end
   end

   // Step through ON/OFF pairs, then the long dark gap; timer resets at each phase end.
   always_comb begin
      phase_next = phase;
      timer_next = timer + 1'b1;
      pulse_next = pulse;
      o_led      = i_en && (phase == BL_ON);
      if (!i_en) begin
         phase_next = BL_ON;
         timer_next = '0;
         pulse_next = '0;
      end else begin
         case (phase)
            BL_ON: begin
               if (timer == HALF_LAST) begin
                  phase_next = BL_OFF;
                  timer_next = '0;
               end
            end
            BL_OFF: begin
               if (timer == HALF_LAST) begin
                  timer_next = '0;
                  pulse_next = pulse + 1'b1;
                  if (pulse_next >= i_count) begin
                     phase_next = BL_GAP;
                     pulse_next = '0;
                  end else begin
                     phase_next = BL_ON;
                  end
               end
            end
            BL_GAP: begin
               if (timer == GAP_LAST) begin
                  phase_next = BL_ON;
                  timer_next = '0;
               end
            end
            default: begin
               phase_next = BL_ON;
               timer_next = '0;
               pulse_next = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/test_sequencer.sv
// test_sequencer: waits a settle period after reset, then runs NUM_TESTS test cores
// one at a time over an en/running/passed/error handshake, aggregates a fail mask
// and reports on the RGB LED (green = all pass, red blink code = first failure).
// Optional build macro WATCHDOG_EN adds a per-test timeout and the o_timeout port.
module test_sequencer
   import test_sequencer_pkg::*;
#(
   parameter int unsigned NUM_TESTS      = 4,
   parameter int unsigned STARTUP_CYCLES = 63,
   parameter bit          STOP_ON_FAIL   = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 48_000_000,
   parameter int unsigned BLINK_CYCLES   = 12_000_000
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   output logic [NUM_TESTS-1:0]    o_test_en,
   input  logic [NUM_TESTS-1:0]    i_running,
   input  logic [NUM_TESTS-1:0]    i_passed,
   input  logic [NUM_TESTS-1:0]    i_error,
   input  logic [16*NUM_TESTS-1:0] i_debug,
   output logic [15:0]             o_debug,
   output logic [NUM_TESTS-1:0]    o_fail_mask,
   output logic                    o_done,
   output logic                    o_led_r,
   output logic                    o_led_g,
   output logic                    o_led_b
`ifdef WATCHDOG_EN
  ,output logic                    o_timeout
`endif
);

   localparam int unsigned IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
   localparam int unsigned SET_W = width_of(STARTUP_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 1);

   seq_state_t           state, state_next;
   logic [SET_W-1:0]     settle, settle_next;
   logic [IDX_W-1:0]     idx, idx_next;
   logic [IDX_W-1:0]     first_fail, first_fail_next;
   logic                 have_fail, have_fail_next;
   logic                 run_q, run_next;
   logic [NUM_TESTS-1:0] test_en_next, fail_mask_next;
   logic [IDX_W-1:0]     dbg_idx;
   logic [IDX_W:0]       blink_count;
   logic                 blink_en, blink_led;
   logic                 sel_running, sel_passed, sel_error;
   logic                 fell, complete, fail_now, timed_out;
   led_t                 led;

`ifdef WATCHDOG_EN
   localparam int unsigned WD_W = width_of(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd;

   // Per-test cycle count, cleared at START; RUN always exits on the limit so it never wraps.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wd        <= '0;
         o_timeout <= 1'b0;
      end else begin
         if (state == ST_START) begin
            wd <= '0;
         end else if (state == ST_RUN && !timed_out) begin
            wd <= wd + 1'b1;
         end
         if (state == ST_RUN && timed_out) begin
            o_timeout <= 1'b1;
         end
      end
   end

   assign timed_out = (wd == WD_LAST);
`else
   assign timed_out = 1'b0;
`endif

   // Only the selected channel's flags take part; error outranks pass.
   always_comb begin
      sel_running = i_running[idx];
      sel_passed  = i_passed[idx];
      sel_error   = i_error[idx];
      fell        = run_q && !sel_running;
      fail_now    = sel_error || (!sel_passed && fell) || timed_out;
      complete    = sel_error || sel_passed || fell || timed_out;
   end

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_SETTLE;
         settle      <= SET_W'(STARTUP_CYCLES);
         idx         <= '0;
         first_fail  <= '0;
         have_fail   <= 1'b0;
         run_q       <= 1'b0;
         o_test_en   <= '0;
         o_fail_mask <= '0;
      end else begin
         state       <= state_next;
         settle      <= settle_next;
         idx         <= idx_next;
         first_fail  <= first_fail_next;
         have_fail   <= have_fail_next;
         run_q       <= run_next;
         o_test_en   <= test_en_next;
         o_fail_mask <= fail_mask_next;
      end
   end

   // Sequencing: SETTLE -> START -> RUN -> GAP -> (START | DONE).
   always_comb begin
      state_next      = state;
      settle_next     = settle;
      idx_next        = idx;
      first_fail_next = first_fail;
      have_fail_next  = have_fail;
      run_next        = run_q;
      test_en_next    = o_test_en;
      fail_mask_next  = o_fail_mask;
      case (state)
         ST_SETTLE: begin
            if (settle != '0) begin
               settle_next = settle - 1'b1;
            end
            // Leave as the count reaches zero so test 0 is enabled STARTUP_CYCLES+1 cycles after release.
            if (settle <= SET_W'(1)) begin
               state_next = ST_START;
               idx_next   = '0;
            end
         end
         ST_START: begin
            test_en_next = NUM_TESTS'(1) << idx;
            run_next     = 1'b0;
            state_next   = ST_RUN;
         end
         ST_RUN: begin
            run_next = sel_running;
            if (complete) begin
               test_en_next = '0;
               state_next   = ST_GAP;
               if (fail_now) begin
                  fail_mask_next[idx] = 1'b1;
                  if (!have_fail) begin
                     first_fail_next = idx;
                     have_fail_next  = 1'b1;
                  end
               end
            end
         end
         ST_GAP: begin
            if (idx == LAST_IDX || (STOP_ON_FAIL && o_fail_mask[idx])) begin
               state_next = ST_DONE;
            end else begin
               idx_next   = idx + 1'b1;
               state_next = ST_START;
            end
         end
         ST_DONE: begin
            test_en_next = '0;
         end
         default: begin
            state_next   = ST_SETTLE;
            test_en_next = '0;
         end
      endcase
   end

   // Status outputs: debug mux, done flag and LED colour.
   always_comb begin
      dbg_idx = (state == ST_DONE && have_fail) ? first_fail : idx;
      o_debug = (state == ST_SETTLE) ? 16'h0000 : i_debug[16*dbg_idx +: 16];
      o_done  = (state == ST_DONE);
      led     = LED_OFF;
      case (state)
         ST_SETTLE: led = LED_BLUE;
         ST_DONE: begin
            if (o_fail_mask == '0) begin
               led = LED_GREEN;
            end else begin
               led.r = blink_led;
            end
         end
         default: begin
            if (|o_fail_mask) begin
               led = LED_RED;
            end
         end
      endcase
      o_led_r = led.r;
      o_led_g = led.g;
      o_led_b = led.b;
   end

   assign blink_en    = (state == ST_DONE) && have_fail;
   assign blink_count = {1'b0, first_fail} + 1'b1;

   blink_code #(
      .BLINK_CYCLES(BLINK_CYCLES),
      .COUNT_W     (IDX_W + 1)
   ) u_blink (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (blink_en),
      .i_count(blink_count),
      .o_led  (blink_led)
   );

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: two instances (halt-on-fail and run-all) share stimulus;
// the one selected by sel is checked against a per-run outcome model.
module tb_test_sequencer;

   localparam int N  = 3;
   localparam int S  = 5;
   localparam int B  = 4;
   localparam int TO = 100;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   running = '0, passed = '0, error = '0;
   logic [16*N-1:0] debug_in = '0;

   logic [N-1:0]   en0, en1, mask0, mask1, en, mask;
   logic [15:0]    dbg0, dbg1, dbg;
   logic           done0, done1, r0, g0, b0, r1, g1, b1, done, r, g, b;
`ifdef WATCHDOG_EN
   logic           to0, to1, to;
`endif

   int checks = 0;
   int errors = 0;
   int sel = 0;
   int oc_t [N];   // 0 pass, 1 error, 2 running drop, 3 pass+error
   int dl_t [N];   // RUN cycles before the outcome flag

   always #5 clk = ~clk;

   test_sequencer #(
      .NUM_TESTS(N), .STARTUP_CYCLES(S), .STOP_ON_FAIL(1'b1),
      .TIMEOUT_CYCLES(TO), .BLINK_CYCLES(B)
   ) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .o_test_en(en0), .i_running(running),
      .i_passed(passed), .i_error(error), .i_debug(debug_in), .o_debug(dbg0),
      .o_fail_mask(mask0), .o_done(done0), .o_led_r(r0), .o_led_g(g0), .o_led_b(b0)
`ifdef WATCHDOG_EN
     ,.o_timeout(to0)
`endif
   );

   test_sequencer #(
      .NUM_TESTS(N), .STARTUP_CYCLES(S), .STOP_ON_FAIL(1'b0),
      .TIMEOUT_CYCLES(TO), .BLINK_CYCLES(B)
   ) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .o_test_en(en1), .i_running(running),
      .i_passed(passed), .i_error(error), .i_debug(debug_in), .o_debug(dbg1),
      .o_fail_mask(mask1), .o_done(done1), .o_led_r(r1), .o_led_g(g1), .o_led_b(b1)
`ifdef WATCHDOG_EN
     ,.o_timeout(to1)
`endif
   );

   always_comb begin
      if (sel == 0) begin
         en = en0; mask = mask0; dbg = dbg0; done = done0; r = r0; g = g0; b = b0;
      end else begin
         en = en1; mask = mask1; dbg = dbg1; done = done1; r = r1; g = g1; b = b1;
      end
`ifdef WATCHDOG_EN
      to = (sel == 0) ? to0 : to1;
`endif
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Reset asserted mid-cycle; returns at the negedge where test 0 must be enabled.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      running = '0; passed = '0; error = '0;
      #1;
      chk("rst_en", 32'(en), 32'(0));
      chk("rst_mask", 32'(mask), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_dbg", 32'(dbg), 32'(0));
      chk("rst_led", 32'({r, g, b}), 32'(3'b001));
`ifdef WATCHDOG_EN
      chk("rst_timeout", 32'(to), 32'(0));
`endif
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < S - 1; i++) tick();
      chk("settle_blue", 32'({r, g, b, en}), 32'({3'b001, 3'b000}));
      tick();
      chk("settle_en", 32'(en), 32'(0));
      tick();
   endtask

   task automatic run_seq(input int s);
      logic [N-1:0] m;
      int ff;
      int n;
      int per;
      int q;
      bit stop;
      bit last;
      m = '0;
      ff = -1;
      stop = (s == 0);
      sel = s;
      do_reset();
      for (int k = 0; k < N; k++) begin
         chk("en_on", 32'(en), 32'(1 << k));
         chk("dbg_run", 32'(dbg), 32'(debug_in[16*k +: 16]));
         chk("led_run_r", 32'(r), 32'(|m));
         running[k] = 1'b1;
         for (int c = 0; c < dl_t[k]; c++) begin
            if (c == 0) begin
               passed[(k + 1) % N] = 1'b1;
               error[(k + 2) % N]  = 1'b1;
            end else if (c == 1) begin
               passed = '0;
               error  = '0;
            end
            tick();
            chk("en_hold", 32'(en), 32'(1 << k));
         end
         case (oc_t[k])
            0: passed[k] = 1'b1;
            1: error[k] = 1'b1;
            2: running[k] = 1'b0;
            default: begin passed[k] = 1'b1; error[k] = 1'b1; end
         endcase
         if (oc_t[k] != 0) begin
            m[k] = 1'b1;
            if (ff < 0) ff = k;
         end
         tick();
         passed = '0; error = '0; running = '0;
         chk("en_off", 32'(en), 32'(0));
         chk("mask", 32'(mask), 32'(m));
         chk("led_warn", 32'({r, g, b}), 32'({|m, 2'b00}));
         tick();
         last = (k == N - 1) || (stop && oc_t[k] != 0);
         chk("gap_en", 32'(en), 32'(0));
         chk("done", 32'(done), 32'(last));
         if (last) begin
            chk("final_mask", 32'(mask), 32'(m));
            chk("final_dbg", 32'(dbg), 32'(debug_in[16*((ff < 0) ? N - 1 : ff) +: 16]));
            if (ff < 0) begin
               chk("led_green", 32'({r, g, b}), 32'(3'b010));
            end else begin
               n = ff + 1;
               per = (2 * n + 4) * B;
               chk("blink_gb", 32'({g, b}), 32'(0));
               for (int p = 0; p < 2 * per; p++) begin
                  q = p % per;
                  chk("blink", 32'(r), 32'((q < 2 * n * B) && ((q / B) % 2 == 0)));
                  tick();
               end
               chk("done_hold", 32'({done, en}), 32'({1'b1, 3'b000}));
            end
            break;
         end
         tick();
      end
   endtask

   task automatic set_case(input int o0, input int o1, input int o2, input int d);
      oc_t[0] = o0; oc_t[1] = o1; oc_t[2] = o2;
      for (int i = 0; i < N; i++) dl_t[i] = d;
      debug_in = {16'($urandom), 16'($urandom), 16'($urandom)};
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=stuck expected=finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      tick();
      // all pass, both builds
      set_case(0, 0, 0, 10); run_seq(0);
      set_case(0, 0, 0, 10); run_seq(1);
      // halt at core 1 error
      set_case(0, 1, 0, 6);  run_seq(0);
      // run-all with cores 0 and 2 failing
      set_case(1, 0, 1, 5);  run_seq(1);
      // running drop and pass+error as fail
      set_case(2, 3, 0, 4);  run_seq(1);
      set_case(0, 3, 0, 3);  run_seq(0);
      // randomized outcomes and latencies
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < N; i++) begin
            oc_t[i] = int'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 0) oc_t[i] = 0;
            dl_t[i] = int'($urandom_range(12, 2));
         end
         debug_in = {16'($urandom), 16'($urandom), 16'($urandom)};
         run_seq(int'($urandom_range(1, 0)));
      end
      // hung core: watchdog fail, or indefinite RUN without it
      sel = 0;
      do_reset();
      running[0] = 1'b1;
      for (int i = 0; i < TO - 1; i++) tick();
      chk("hang_en_before", 32'(en), 32'(1));
      tick();
`ifdef WATCHDOG_EN
      chk("wd_en_off", 32'(en), 32'(0));
      chk("wd_mask", 32'(mask), 32'(1));
      chk("wd_timeout", 32'(to), 32'(1));
`else
      for (int i = 0; i < 50; i++) tick();
      chk("hang_en_held", 32'({done, en}), 32'({1'b0, 3'b001}));
`endif
      // reset mid-RUN, then a clean sequence
      sel = 0;
      do_reset();
      running[0] = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("pre_reset_en", 32'(en), 32'(1));
      set_case(0, 0, 0, 7); run_seq(0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
